// File: rtl/ysyx_24110015_pkg.sv
// ysyx_24110015_pkg: shared FSM state encoding and owner constants for the memory arbiter.
package ysyx_24110015_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;
endpackage

// File: rtl/ysyx_24110015_arb_pick.sv
// ysyx_24110015_arb_pick: picks the winner between two requesters.
// A tie goes to the master that was not granted last.
module ysyx_24110015_arb_pick
  import ysyx_24110015_pkg::*;
(
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_i,
  output logic win_o
);
  assign win_o = (v0_i && v1_i) ? ~last_i : (v1_i ? OWN_M1 : OWN_M0);
endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter: two-master (IFU/LSU) to one-slave memory arbiter, one transaction outstanding.
// Define YSYX_ARB_RR_EN for round-robin ties; otherwise the LSU (m1) wins ties.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_wen,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wmask,
  output logic            m0_resp_valid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_wen,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  output logic            m1_resp_valid,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_req_valid,
  input  logic            s_req_ready,
  output logic [AW-1:0]   s_addr,
  output logic            s_wen,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wmask,
  input  logic            s_resp_valid,
  input  logic [DW-1:0]   s_rdata,
  output logic            busy
);
  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   win, last, any_req;
  assign any_req = m0_req_valid || m1_req_valid;
`ifdef YSYX_ARB_RR_EN
  logic last_q, last_d;
  assign last_d = (state_q == IDLE && any_req) ? win : last_q;
  assign last   = last_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= OWN_M1;
    else      last_q <= last_d;
`else
  // a constant "m0 granted last" makes every tie resolve to m1
  assign last = OWN_M0;
`endif
  ysyx_24110015_arb_pick u_pick (
    .v0_i   (m0_req_valid),
    .v1_i   (m1_req_valid),
    .last_i (last),
    .win_o  (win)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_M0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    s_req_valid   = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;
    s_addr        = owner_q ? m1_addr  : m0_addr;
    s_wen         = owner_q ? m1_wen   : m0_wen;
    s_wdata       = owner_q ? m1_wdata : m0_wdata;
    s_wmask       = owner_q ? m1_wmask : m0_wmask;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = REQ;
        owner_d = win;
      end
      REQ: begin
        s_req_valid  = owner_q ? m1_req_valid : m0_req_valid;
        m0_req_ready = !owner_q && s_req_ready;
        m1_req_ready = owner_q && s_req_ready;
        state_d      = (s_req_valid && s_req_ready) ? RESP : REQ;
      end
      RESP: begin
        m0_resp_valid = !owner_q && s_resp_valid;
        m1_resp_valid = owner_q && s_resp_valid;
        state_d       = s_resp_valid ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// tb_ysyx_24110015_mem_arbiter: directed and randomized checks of the arbiter against a transaction-level model.
module tb_ysyx_24110015_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic            clk, rst;
  logic            m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata, m0_rdata;
  logic [DW/8-1:0] m0_wmask;
  logic            m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata, m1_rdata;
  logic [DW/8-1:0] m1_wmask;
  logic            s_req_valid, s_req_ready, s_wen, s_resp_valid, busy;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [DW/8-1:0] s_wmask;
  int total = 0;
  int bad = 0;
  bit m_last = 1'b1;
  ysyx_24110015_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_resp_valid(s_resp_valid), .s_rdata(s_rdata), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rand_payload();
    m0_addr = $urandom; m0_wen = 1'($urandom); m0_wdata = $urandom; m0_wmask = 4'($urandom);
    m1_addr = $urandom; m1_wen = 1'($urandom); m1_wdata = $urandom; m1_wmask = 4'($urandom);
  endtask
  // One full transaction; the expected owner comes from the arbitration rule applied to the request pair.
  task automatic run_txn(input bit v0, input bit v1, input int stall, input int delay, input logic [DW-1:0] rd, output bit got);
    bit exp;
    logic [AW+DW+DW/8:0] ep;
    if (v0 && v1) begin
`ifdef YSYX_ARB_RR_EN
      exp = ~m_last;
`else
      exp = 1'b1;
`endif
    end else exp = v1;
    m_last = exp;
    ep = exp ? {m1_addr, m1_wen, m1_wdata, m1_wmask} : {m0_addr, m0_wen, m0_wdata, m0_wmask};
    m0_req_valid = v0; m1_req_valid = v1; s_req_ready = 1'b0; s_resp_valid = 1'($urandom_range(0, 1));
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL idle_s_req_valid got=%0b exp=0", s_req_valid); end
    total++; if ({m1_req_ready, m0_req_ready} !== 2'b00) begin bad++; $display("FAIL idle_ready got=%b exp=00", {m1_req_ready, m0_req_ready}); end
    total++; if ({m1_resp_valid, m0_resp_valid} !== 2'b00) begin bad++; $display("FAIL idle_resp got=%b exp=00", {m1_resp_valid, m0_resp_valid}); end
    step();
    s_resp_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      total++; if (s_req_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL stall_valid_busy got=%b exp=11", {s_req_valid, busy}); end
      total++; if ({s_addr, s_wen, s_wdata, s_wmask} !== ep) begin bad++; $display("FAIL stall_payload got=%h exp=%h", {s_addr, s_wen, s_wdata, s_wmask}, ep); end
      total++; if ({m1_req_ready, m0_req_ready} !== 2'b00) begin bad++; $display("FAIL stall_ready got=%b exp=00", {m1_req_ready, m0_req_ready}); end
      step();
    end
    s_req_ready = 1'b1;
    #1;
    total++; if ({m1_req_ready, m0_req_ready} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL grant_ready got=%b exp=%b", {m1_req_ready, m0_req_ready}, exp ? 2'b10 : 2'b01); end
    total++; if ({s_addr, s_wen, s_wdata, s_wmask} !== ep) begin bad++; $display("FAIL grant_payload got=%h exp=%h", {s_addr, s_wen, s_wdata, s_wmask}, ep); end
    total++; if (s_req_valid !== 1'b1) begin bad++; $display("FAIL grant_s_req_valid got=%0b exp=1", s_req_valid); end
    got = m1_req_ready;
    step();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b1;
    for (int i = 0; i < delay; i++) begin
      #1;
      total++; if ({m1_resp_valid, m0_resp_valid, busy} !== 3'b001) begin bad++; $display("FAIL wait_resp got=%b exp=001", {m1_resp_valid, m0_resp_valid, busy}); end
      step();
    end
    s_resp_valid = 1'b1; s_rdata = rd;
    #1;
    total++; if ({m1_resp_valid, m0_resp_valid} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL resp_valid got=%b exp=%b", {m1_resp_valid, m0_resp_valid}, exp ? 2'b10 : 2'b01); end
    total++; if (m0_rdata !== rd || m1_rdata !== rd) begin bad++; $display("FAIL resp_rdata got=%h/%h exp=%h", m0_rdata, m1_rdata, rd); end
    total++; if ({m1_req_ready, m0_req_ready} !== 2'b00) begin bad++; $display("FAIL resp_ready got=%b exp=00", {m1_req_ready, m0_req_ready}); end
    step();
    s_resp_valid = 1'b0; s_req_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1; s_resp_valid = 1'b1;
    m0_addr = 32'h1111_0000; m1_addr = 32'h2222_0000;
    repeat (2) step();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL reset_s_req_valid got=%0b exp=0", s_req_valid); end
    total++; if ({m1_req_ready, m0_req_ready, m1_resp_valid, m0_resp_valid} !== 4'b0) begin bad++; $display("FAIL reset_hs got=%b exp=0000", {m1_req_ready, m0_req_ready, m1_resp_valid, m0_resp_valid}); end
    total++; if (s_addr !== 32'h1111_0000) begin bad++; $display("FAIL reset_s_addr got=%h exp=11110000", s_addr); end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b0; s_resp_valid = 1'b0;
    step();
    rst = 1'b1; m_last = 1'b1;
    step();
  endtask
  task automatic test_priority();
    bit got;
    bit [2:0] seq;
`ifdef YSYX_ARB_RR_EN
    seq = 3'b010;
`else
    seq = 3'b111;
`endif
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      run_txn(1'b1, 1'b1, 0, 0, $urandom, got);
      total++; if (got !== seq[i]) begin bad++; $display("FAIL priority_%0d got=m%0d exp=m%0d", i, got, seq[i]); end
    end
    rand_payload();
    run_txn(1'b1, 1'b0, 0, 0, $urandom, got);
    total++; if (got !== 1'b0) begin bad++; $display("FAIL priority_m0_next got=m%0d exp=m0", got); end
  endtask
  task automatic test_single_read();
    bit got;
    m0_addr = 32'h8000_0000; m0_wen = 1'b0; m0_wdata = '0; m0_wmask = '0;
    run_txn(1'b1, 1'b0, 0, 1, 32'h0010_0073, got);
    #1;
    total++; if (got !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_read owner/busy got=%b exp=00", {got, busy}); end
  endtask
  task automatic test_backpressure();
    bit got;
    m1_addr = 32'h8000_1000; m1_wen = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
    run_txn(1'b0, 1'b1, 3, 0, $urandom, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL backpressure_owner got=m%0d exp=m1", got); end
  endtask
  task automatic test_back_to_back();
    bit got;
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      run_txn(1'b1, 1'b1, 0, 0, $urandom, got);
    end
  endtask
  task automatic test_spurious();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_resp_valid = 1'b1; s_rdata = $urandom;
    repeat (2) begin
      #1;
      total++; if ({m1_resp_valid, m0_resp_valid, busy} !== 3'b000) begin bad++; $display("FAIL spurious_idle got=%b exp=000", {m1_resp_valid, m0_resp_valid, busy}); end
      step();
    end
    rand_payload();
    m0_req_valid = 1'b1; s_req_ready = 1'b0; m_last = 1'b0;
    step();
    m1_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({m1_req_ready, m1_resp_valid, m0_resp_valid, s_req_valid} !== 4'b0001) begin bad++; $display("FAIL spurious_req got=%b exp=0001", {m1_req_ready, m1_resp_valid, m0_resp_valid, s_req_valid}); end
      step();
    end
    m0_req_valid = 1'b0;
    #1;
    total++; if ({s_req_valid, busy, m1_req_ready} !== 3'b010) begin bad++; $display("FAIL owner_drop got=%b exp=010", {s_req_valid, busy, m1_req_ready}); end
    step();
    m0_req_valid = 1'b1; s_req_ready = 1'b1; s_resp_valid = 1'b0;
    #1;
    total++; if ({m1_req_ready, m0_req_ready} !== 2'b01) begin bad++; $display("FAIL spurious_accept got=%b exp=01", {m1_req_ready, m0_req_ready}); end
    step();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b0;
    s_resp_valid = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    total++; if ({m1_resp_valid, m0_resp_valid, m0_rdata} !== {2'b01, 32'h1234_5678}) begin bad++; $display("FAIL spurious_resp got=%b/%h exp=01/12345678", {m1_resp_valid, m0_resp_valid}, m0_rdata); end
    step();
    s_resp_valid = 1'b0;
  endtask
  task automatic test_reset_abort();
    rand_payload();
    m1_req_valid = 1'b1; s_req_ready = 1'b1;
    step();
    step();
    m1_req_valid = 1'b0; s_req_ready = 1'b0;
    #1;
    total++; if ({busy, m1_resp_valid} !== 2'b10) begin bad++; $display("FAIL abort_in_resp got=%b exp=10", {busy, m1_resp_valid}); end
    #1 rst = 1'b0;
    #1;
    total++; if ({busy, s_req_valid} !== 2'b00) begin bad++; $display("FAIL abort_async got=%b exp=00", {busy, s_req_valid}); end
    total++; if (s_addr !== m0_addr) begin bad++; $display("FAIL abort_owner got=%h exp=%h", s_addr, m0_addr); end
    step();
    rst = 1'b1; m_last = 1'b1;
    s_resp_valid = 1'b1; s_rdata = $urandom;
    #1;
    total++; if ({m1_resp_valid, m0_resp_valid, busy} !== 3'b000) begin bad++; $display("FAIL abort_late_resp got=%b exp=000", {m1_resp_valid, m0_resp_valid, busy}); end
    step();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0b exp=0", busy); end
    s_resp_valid = 1'b0;
    step();
  endtask
  task automatic test_random();
    bit got;
    int pick;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(1, 3);
      rand_payload();
      run_txn(pick[0], pick[1], $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got);
    end
  endtask
  initial begin
    m0_req_valid = 0; m0_addr = 0; m0_wen = 0; m0_wdata = 0; m0_wmask = 0;
    m1_req_valid = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wmask = 0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = 0; rst = 0;
    @(negedge clk);
    test_reset();
    test_priority();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_spurious();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
